// File: rtl/ppu_frame_timer.sv
// Parametrised PPU raster timing: dot/line counters, vblank flag with status-read race, NMI, frame pulses.
// Define ODD_FRAME_SKIP_EN to drop the last pre-render dot on odd frames while rendering is enabled.
module ppu_frame_timer #(
  parameter int H_TOTAL     = 341,
  parameter int H_VISIBLE   = 256,
  parameter int V_TOTAL     = 262,
  parameter int V_VISIBLE   = 240,
  parameter int VBLANK_LINE = 241,
  parameter int CNT_W       = 9,
  parameter int FRAME_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               render_en,
  input  logic               nmi_en,
  input  logic               status_rd,
  output logic [CNT_W-1:0]   pixel_x,
  output logic [CNT_W-1:0]   scanline_y,
  output logic               vblank_flag,
  output logic               nmi,
  output logic               visible,
  output logic               prerender,
  output logic               frame_start,
  output logic               frame_end,
  output logic               odd_frame,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_VIS   = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_VIS   = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] Y_VBL   = CNT_W'(VBLANK_LINE);
  localparam logic [CNT_W-1:0] Y_FEND  = CNT_W'(V_VISIBLE - 1);
  localparam logic [CNT_W-1:0] X_ZERO  = '0;
  localparam logic [CNT_W-1:0] X_ONE   = CNT_W'(1);

  logic [CNT_W-1:0]   x_q, x_d;
  logic [CNT_W-1:0]   y_q, y_d;
  logic               odd_q, odd_d;
  logic [FRAME_W-1:0] fcnt_q, fcnt_d;
  logic               vbl_q, vbl_d;
  logic               sup_q, sup_d;

  logic line_end;
  logic frame_wrap;
  logic skip_dot;
  logic set_hit;
  logic clr_hit;
  logic arm_hit;

`ifdef ODD_FRAME_SKIP_EN
  localparam logic [CNT_W-1:0] X_SKIP = CNT_W'(H_TOTAL - 2);
  assign skip_dot = (y_q == Y_LAST) && (x_q == X_SKIP) && odd_q && render_en;
`else
  logic unused_render_en;
  assign unused_render_en = render_en;
  assign skip_dot         = 1'b0;
`endif

  assign line_end   = (x_q == X_LAST) || skip_dot;
  assign frame_wrap = line_end && (y_q == Y_LAST);

  always_comb begin
    x_d    = x_q + X_ONE;
    y_d    = y_q;
    odd_d  = odd_q;
    fcnt_d = fcnt_q;
    if (line_end) begin
      x_d = '0;
      if (frame_wrap) begin
        y_d    = '0;
        odd_d  = ~odd_q;
        fcnt_d = fcnt_q + FRAME_W'(1);
      end else begin
        y_d = y_q + X_ONE;
      end
    end
  end

  assign set_hit = (x_q == X_ONE)  && (y_q == Y_VBL);
  assign clr_hit = (x_q == X_ONE)  && (y_q == Y_LAST);
  assign arm_hit = (x_q == X_ZERO) && (y_q == Y_VBL);

  // A read landing on the set edge (or the dot before it) hides this frame's NMI;
  // the hide lasts until the pre-render clear.
  always_comb begin
    vbl_d = vbl_q;
    sup_d = sup_q;
    if (set_hit) begin
      if (status_rd) begin
        vbl_d = 1'b0;
        sup_d = 1'b1;
      end else begin
        vbl_d = 1'b1;
      end
    end else if (status_rd) begin
      vbl_d = 1'b0;
    end else if (clr_hit) begin
      vbl_d = 1'b0;
    end
    if (arm_hit && status_rd) sup_d = 1'b1;
    if (clr_hit)              sup_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= Y_LAST;
      odd_q  <= 1'b0;
      fcnt_q <= '0;
      vbl_q  <= 1'b0;
      sup_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      odd_q  <= odd_d;
      fcnt_q <= fcnt_d;
      vbl_q  <= vbl_d;
      sup_q  <= sup_d;
    end
  end

  assign pixel_x     = x_q;
  assign scanline_y  = y_q;
  assign vblank_flag = vbl_q;
  assign odd_frame   = odd_q;
  assign frame_cnt   = fcnt_q;
  assign nmi         = vbl_q & nmi_en & ~sup_q;

  assign visible     = (y_q < Y_VIS) && (x_q >= X_ONE) && (x_q <= X_VIS);
  assign prerender   = (y_q == Y_LAST);
  assign frame_start = (x_q == X_ZERO) && (y_q == '0);
  assign frame_end   = (x_q == X_LAST) && (y_q == Y_FEND);

endmodule

// File: tb/tb_ppu_frame_timer.sv
// Directed bench for ppu_frame_timer on a shrunken raster (20 dots x 12 lines) to keep runs short.
module tb_ppu_frame_timer;
  localparam int HT = 20, HV = 16, VT = 12, VV = 8, VBL = 9, CW = 5, FW = 4;
  localparam int FRAME = HT * VT;

  logic clk, rst, render_en, nmi_en, status_rd;
  logic [CW-1:0] pixel_x, scanline_y;
  logic vblank_flag, nmi, visible, prerender, frame_start, frame_end, odd_frame;
  logic [FW-1:0] frame_cnt;
  int tests, fails;

  ppu_frame_timer #(.H_TOTAL(HT), .H_VISIBLE(HV), .V_TOTAL(VT), .V_VISIBLE(VV),
                    .VBLANK_LINE(VBL), .CNT_W(CW), .FRAME_W(FW)) dut (
    .clk(clk), .rst(rst), .render_en(render_en), .nmi_en(nmi_en), .status_rd(status_rd),
    .pixel_x(pixel_x), .scanline_y(scanline_y), .vblank_flag(vblank_flag), .nmi(nmi),
    .visible(visible), .prerender(prerender), .frame_start(frame_start), .frame_end(frame_end),
    .odd_frame(odd_frame), .frame_cnt(frame_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Advance until (tx,ty); an overrun counts as a failed comparison.
  task automatic goto(input int tx, input int ty);
    int n = 0;
    while (!(int'(pixel_x) == tx && int'(scanline_y) == ty) && n < 2 * FRAME) begin
      step(); n++;
    end
    if (n >= 2 * FRAME) begin
      tests++; fails++;
      $display("FAIL goto(%0d,%0d): stuck at (%0d,%0d)", tx, ty, pixel_x, scanline_y);
    end
  endtask

  task automatic test_reset();
    int n = 0;
    rst = 1'b1; step(); step();
    tests++; if (pixel_x !== 0 || scanline_y !== CW'(VT-1)) begin fails++;
      $display("FAIL reset_pos: got (%0d,%0d) want (0,%0d)", pixel_x, scanline_y, VT-1); end
    tests++; if ({vblank_flag, nmi, odd_frame} !== 3'b000 || frame_cnt !== 0) begin fails++;
      $display("FAIL reset_state: vbl=%b nmi=%b odd=%b fc=%0d want 0", vblank_flag, nmi, odd_frame, frame_cnt); end
    tests++; if (prerender !== 1'b1) begin fails++;
      $display("FAIL reset_prerender: got %b want 1", prerender); end
    rst = 1'b0;
    while (!frame_start && n < 2 * FRAME) begin step(); n++; end
    tests++; if (n != HT) begin fails++;
      $display("FAIL first_frame_start: got %0d clks want %0d", n, HT); end
    tests++; if (odd_frame !== 1'b1 || frame_cnt !== 1) begin fails++;
      $display("FAIL first_wrap: odd=%b fc=%0d want odd=1 fc=1", odd_frame, frame_cnt); end
  endtask

  // Returns clocks from the current frame_start to the next one.
  task automatic measure(output int n);
    n = 0;
    do begin step(); n++; end while (!frame_start && n < 2 * FRAME);
  endtask

  task automatic test_frame_len();
    int n, exp_a;
`ifdef ODD_FRAME_SKIP_EN
    exp_a = FRAME - 1;
`else
    exp_a = FRAME;
`endif
    render_en = 1'b1;
    measure(n);
    tests++; if (n != exp_a) begin fails++;
      $display("FAIL frame_len_odd: got %0d want %0d", n, exp_a); end
    tests++; if (odd_frame !== 1'b0 || frame_cnt !== 2) begin fails++;
      $display("FAIL frame_wrap_a: odd=%b fc=%0d want odd=0 fc=2", odd_frame, frame_cnt); end
    measure(n);
    tests++; if (n != FRAME) begin fails++;
      $display("FAIL frame_len_even: got %0d want %0d", n, FRAME); end
    render_en = 1'b0;
    measure(n);
    tests++; if (n != FRAME) begin fails++;
      $display("FAIL frame_len_norender: got %0d want %0d", n, FRAME); end
    tests++; if (odd_frame !== 1'b0 || frame_cnt !== 4) begin fails++;
      $display("FAIL frame_wrap_c: odd=%b fc=%0d want odd=0 fc=4", odd_frame, frame_cnt); end
    render_en = 1'b1;
  endtask

  task automatic test_frame_wrap();
    int n;
    int exp_fc = 4;
    logic exp_odd = 1'b0;
    for (int k = 0; k < 14; k++) begin
      measure(n);
      exp_fc = (exp_fc + 1) % 16; exp_odd = ~exp_odd;
      tests++; if (frame_cnt !== FW'(exp_fc) || odd_frame !== exp_odd) begin fails++;
        $display("FAIL frame_cnt_wrap[%0d]: fc=%0d odd=%b want fc=%0d odd=%b", k, frame_cnt, odd_frame, exp_fc, exp_odd); end
    end
  endtask

  task automatic test_decode();
    tests++; if (frame_start !== 1'b1 || visible !== 1'b0) begin fails++;
      $display("FAIL decode_00: fs=%b vis=%b want fs=1 vis=0", frame_start, visible); end
    goto(1, 0);
    tests++; if (visible !== 1'b1 || frame_start !== 1'b0) begin fails++;
      $display("FAIL decode_10: vis=%b fs=%b want vis=1 fs=0", visible, frame_start); end
    goto(HV, VV-1);
    tests++; if (visible !== 1'b1) begin fails++;
      $display("FAIL decode_last_vis: got %b want 1", visible); end
    step();
    tests++; if (visible !== 1'b0) begin fails++;
      $display("FAIL decode_past_vis: got %b want 0", visible); end
    goto(HT-1, VV-1);
    tests++; if (frame_end !== 1'b1 || visible !== 1'b0) begin fails++;
      $display("FAIL decode_frame_end: fe=%b vis=%b want fe=1 vis=0", frame_end, visible); end
    step();
    tests++; if (frame_end !== 1'b0 || visible !== 1'b0 || prerender !== 1'b0) begin fails++;
      $display("FAIL decode_line_vv: fe=%b vis=%b pre=%b want 0", frame_end, visible, prerender); end
    goto(0, VT-1);
    tests++; if (prerender !== 1'b1) begin fails++;
      $display("FAIL decode_prerender: got %b want 1", prerender); end
  endtask

  task automatic test_vblank();
    nmi_en = 1'b1;
    goto(1, VBL);
    tests++; if (vblank_flag !== 1'b0) begin fails++;
      $display("FAIL vbl_before_set: got %b want 0", vblank_flag); end
    step();
    tests++; if (vblank_flag !== 1'b1 || nmi !== 1'b1) begin fails++;
      $display("FAIL vbl_set: vbl=%b nmi=%b want 1 1", vblank_flag, nmi); end
    nmi_en = 1'b0; #1;
    tests++; if (nmi !== 1'b0 || vblank_flag !== 1'b1) begin fails++;
      $display("FAIL nmi_en_off: nmi=%b vbl=%b want 0 1", nmi, vblank_flag); end
    nmi_en = 1'b1; #1;
    tests++; if (nmi !== 1'b1) begin fails++;
      $display("FAIL nmi_en_rearm: got %b want 1", nmi); end
    status_rd = 1'b1; step(); status_rd = 1'b0;
    tests++; if (vblank_flag !== 1'b0 || nmi !== 1'b0) begin fails++;
      $display("FAIL status_clear: vbl=%b nmi=%b want 0 0", vblank_flag, nmi); end
    goto(1, VBL); step();
    goto(1, VT-1);
    tests++; if (vblank_flag !== 1'b1) begin fails++;
      $display("FAIL vbl_held: got %b want 1", vblank_flag); end
    step();
    tests++; if (vblank_flag !== 1'b0 || nmi !== 1'b0) begin fails++;
      $display("FAIL prerender_clear: vbl=%b nmi=%b want 0 0", vblank_flag, nmi); end
  endtask

  task automatic test_race();
    goto(1, VBL);
    status_rd = 1'b1; step(); status_rd = 1'b0;
    tests++; if (vblank_flag !== 1'b0 || nmi !== 1'b0) begin fails++;
      $display("FAIL race_set_edge: vbl=%b nmi=%b want 0 0", vblank_flag, nmi); end
    goto(0, VT-1);
    tests++; if (vblank_flag !== 1'b0 || nmi !== 1'b0) begin fails++;
      $display("FAIL race_frame: vbl=%b nmi=%b want 0 0", vblank_flag, nmi); end
    goto(1, VBL); step();
    tests++; if (vblank_flag !== 1'b1 || nmi !== 1'b1) begin fails++;
      $display("FAIL race_next_frame: vbl=%b nmi=%b want 1 1", vblank_flag, nmi); end
  endtask

  task automatic test_race_early();
    goto(0, VBL);
    status_rd = 1'b1; step(); status_rd = 1'b0;
    tests++; if (vblank_flag !== 1'b0) begin fails++;
      $display("FAIL early_pre_set: got %b want 0", vblank_flag); end
    step();
    tests++; if (vblank_flag !== 1'b1 || nmi !== 1'b0) begin fails++;
      $display("FAIL early_suppress: vbl=%b nmi=%b want 1 0", vblank_flag, nmi); end
    goto(1, VBL); step();
    tests++; if (nmi !== 1'b1) begin fails++;
      $display("FAIL early_next_frame: nmi=%b want 1", nmi); end
  endtask

  task automatic test_reset_mid();
    goto(5, 3);
    #2 rst = 1'b1; #1;
    tests++; if (pixel_x !== 0 || scanline_y !== CW'(VT-1) || frame_cnt !== 0 || odd_frame !== 1'b0) begin fails++;
      $display("FAIL reset_mid: (%0d,%0d) fc=%0d odd=%b want (0,%0d) fc=0 odd=0", pixel_x, scanline_y, frame_cnt, odd_frame, VT-1); end
    step(); rst = 1'b0;
    goto(1, VBL); step();
    tests++; if (vblank_flag !== 1'b1) begin fails++;
      $display("FAIL reset_vbl_pre: got %b want 1", vblank_flag); end
    #2 rst = 1'b1; #1;
    tests++; if (vblank_flag !== 1'b0 || nmi !== 1'b0) begin fails++;
      $display("FAIL reset_vbl: vbl=%b nmi=%b want 0 0", vblank_flag, nmi); end
    step(); rst = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; render_en = 1'b1; nmi_en = 1'b1; status_rd = 1'b0;
    test_reset();
    test_frame_len();
    test_frame_wrap();
    test_decode();
    test_vblank();
    test_race();
    test_race_early();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
